// File: rtl/wr_ctrl.sv
`default_nettype none
// =============================================================================
// wr_ctrl : writes one ROW x CLO row-major frame into the transpose RAM and
//           hands it to the column-order reader, blocking input until read done.
// Rev 1.0
// =============================================================================
module wr_ctrl #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int ROW        = 64,
  parameter int CLO        = 2400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_command,
  input  logic                  rd_finish,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int COL_W = (CLO > 1) ? $clog2(CLO) : 1;
  localparam int ROW_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [COL_W-1:0]      C_COL_LAST = COL_W'(CLO - 1);
  localparam logic [ROW_W-1:0]      C_ROW_LAST = ROW_W'(ROW - 1);
  localparam logic [ADDR_WIDTH-1:0] C_PIX_LAST = ADDR_WIDTH'(ROW * CLO - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    HANDOFF = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  state_t                r_state;
  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_WIDTH-1:0] r_pix;

  logic                  w_accept;
  logic                  w_take;
  logic [COL_W-1:0]      w_col;
  logic [ROW_W-1:0]      w_row;
  logic [ADDR_WIDTH-1:0] w_pix;
  logic [COL_W-1:0]      w_col_nxt;
  logic [ROW_W-1:0]      w_row_nxt;
  logic [ADDR_WIDTH-1:0] w_pix_nxt;

  assign s_ready  = (r_state == IDLE) || (r_state == WRITE);
  assign busy     = (r_state != IDLE);
  assign w_accept = s_valid && s_ready;
  // In IDLE only a start-of-frame beat becomes a pixel; everything else is dropped.
  assign w_take   = w_accept && ((r_state == WRITE) || s_sof);

  // Index of the pixel carried by this beat: a start-of-frame always means pixel 0.
  always_comb begin
    w_col     = s_sof ? '0 : r_col;
    w_row     = s_sof ? '0 : r_row;
    w_pix     = s_sof ? '0 : r_pix;
    w_pix_nxt = w_pix + ADDR_WIDTH'(1);
    if (w_col == C_COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == C_ROW_LAST) ? '0 : w_row + ROW_W'(1);
    end else begin
      w_col_nxt = w_col + COL_W'(1);
      w_row_nxt = w_row;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_pix      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_command <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      rd_command <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        IDLE, WRITE: begin
          if (w_take) begin
            wr_en     <= 1'b1;
            wr_addr   <= w_pix;
            wr_data   <= s_data;
            frame_err <= (r_state == WRITE) && s_sof && (r_pix != '0);
            if (w_pix == C_PIX_LAST) begin
              r_state <= HANDOFF;
            end else begin
              r_state <= WRITE;
              r_col   <= w_col_nxt;
              r_row   <= w_row_nxt;
              r_pix   <= w_pix_nxt;
            end
          end
        end
        // The last write lands this cycle, so the reader starts one cycle later.
        HANDOFF: begin
          rd_command <= 1'b1;
          r_state    <= WAIT_RD;
        end
        WAIT_RD: begin
          if (rd_finish) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_pix   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
